// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
// The requester drives the master side; muldiv_unit sits on the slave side.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] dInA;
  logic [WIDTH-1:0] dInB;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hiOut;
  logic [WIDTH-1:0] loOut;

  modport master (
    output start, op, dInA, dInB, flush,
    input  busy, done, hiOut, loOut
  );

  modport slave (
    input  start, op, dInA, dInB, flush,
    output busy, done, hiOut, loOut
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers for the EX stage.
// Define MDU_DIV_EN to build the restoring divider; otherwise DIV/DIVU are no-ops.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           rst_n,
  muldiv_unit_if.slave  mdu
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   hi, lo;
  logic               busy, done;
  logic               neg_q;

  logic               sgn, a_neg, b_neg;
  logic [WIDTH-1:0]   amag, bmag;
  logic               go_mul, go_div;
  logic [WIDTH:0]     msum;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   hi_n, lo_n;

`ifdef MDU_DIV_EN
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   araw;
  logic               is_div, neg_r, dz;
  logic [WIDTH:0]     rsh, dif;
  logic               ok;
`endif

  assign sgn   = ~mdu.op[0];
  assign a_neg = sgn & mdu.dInA[WIDTH-1];
  assign b_neg = sgn & mdu.dInB[WIDTH-1];
  assign amag  = a_neg ? (~mdu.dInA + 1'b1) : mdu.dInA;
  assign bmag  = b_neg ? (~mdu.dInB + 1'b1) : mdu.dInB;
  assign go_mul = (mdu.op[2:1] == 2'b00);
`ifdef MDU_DIV_EN
  assign go_div = (mdu.op[2:1] == 2'b01);
`else
  assign go_div = 1'b0;
`endif

  // Shift-add: low half of acc holds the remaining multiplier bits.
  assign msum = {1'b0, acc[2*WIDTH-1:WIDTH]}
              + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});

`ifdef MDU_DIV_EN
  assign rsh = {rem[WIDTH-1:0], acc[WIDTH-1]};
  assign dif = rsh - {1'b0, opnd};
  assign ok  = ~dif[WIDTH];
`endif

  always_comb begin
    prod = neg_q ? (~acc + 1'b1) : acc;
    hi_n = prod[2*WIDTH-1:WIDTH];
    lo_n = prod[WIDTH-1:0];
`ifdef MDU_DIV_EN
    if (is_div) begin
      if (dz) begin
        lo_n = '1;
        hi_n = araw;
      end else begin
        lo_n = neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        hi_n = neg_r ? (~rem[WIDTH-1:0] + 1'b1) : rem[WIDTH-1:0];
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      acc   <= '0;
      opnd  <= '0;
      neg_q <= 1'b0;
`ifdef MDU_DIV_EN
      rem    <= '0;
      araw   <= '0;
      is_div <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mdu.start && !mdu.flush) begin
            if (go_mul || go_div) begin
              acc   <= {{WIDTH{1'b0}}, amag};
              opnd  <= bmag;
              neg_q <= a_neg ^ b_neg;
              cnt   <= '0;
              busy  <= 1'b1;
              state <= S_RUN;
`ifdef MDU_DIV_EN
              rem    <= '0;
              araw   <= mdu.dInA;
              is_div <= go_div;
              neg_r  <= a_neg;
              dz     <= (mdu.dInB == '0);
`endif
            end else if (mdu.op == 3'b100) begin
              hi <= mdu.dInA;
            end else if (mdu.op == 3'b101) begin
              lo <= mdu.dInA;
            end
          end
        end
        S_RUN: begin
          if (mdu.flush) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
`ifdef MDU_DIV_EN
            if (is_div) begin
              acc[WIDTH-1:0] <= {acc[WIDTH-2:0], ok};
              rem <= ok ? dif : rsh;
            end else begin
              acc <= {msum, acc[WIDTH-1:1]};
            end
`else
            acc <= {msum, acc[WIDTH-1:1]};
`endif
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= S_FIX;
          end
        end
        S_FIX: begin
          busy  <= 1'b0;
          state <= S_IDLE;
          if (!mdu.flush) begin
            hi   <= hi_n;
            lo   <= lo_n;
            done <= 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign mdu.busy  = busy;
  assign mdu.done  = done;
  assign mdu.hiOut = hi;
  assign mdu.loOut = lo;
endmodule
